// File: rtl/alu_issue_scheduler_pkg.sv
// Shared types and constants for the two-port ALU issue scheduler.
package alu_issue_scheduler_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_OP_MULT = 4'b0010;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE  = 2'd0;
    localparam sched_state_t ST_EXEC  = 2'd1;
    localparam sched_state_t ST_MUL   = 2'd2;
    localparam sched_state_t ST_BLOCK = 2'd3;

endpackage

// File: rtl/alu_issue_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: grants a lone requester, alternates on ties,
// and moves its priority only when the granted request is actually accepted.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant0,
    output logic grant1
);

    // prio1 = 1 means port 1 wins the next tie
    logic prio1;

    assign grant0 = valid0 && (!valid1 || !prio1);
    assign grant1 = valid1 && (!valid0 || prio1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio1 <= 1'b0;
        end else if (accept && grant0) begin
            prio1 <= 1'b1;
        end else if (accept && grant1) begin
            prio1 <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Shares one ALU between two issue ports: round-robin grant, an execute
// register driving the ALU (held MUL_LAT cycles for MULT) and a result register.
module alu_issue_scheduler
    import alu_issue_scheduler_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 6,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  alu_op_t          req0_op,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  alu_op_t          req1_op,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output alu_op_t          alu_op,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    input  logic [XLEN-1:0]  alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_src
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);
    localparam bit MUL_MULTI = (MUL_LAT > 1);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [CNT_W-1:0] cnt;
    alu_op_t          e_op;
    logic [XLEN-1:0]  e_a;
    logic [XLEN-1:0]  e_b;
    logic [TAG_W-1:0] e_tag;
    logic             e_src;

    logic e_valid;
    logic e_done;
    logic w_load;
    logic e_accept;
    logic grant0;
    logic grant1;
    logic take;
    logic sel;

    alu_op_t          in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;

    assign e_valid  = (state != ST_IDLE);
    assign e_done   = e_valid && (e_op != ALU_OP_MULT || cnt == CNT_LAST);
    assign w_load   = e_done && (!out_valid || out_ready);
    assign e_accept = !flush && (!e_valid || w_load);

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .accept (e_accept),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    // rst_n gating keeps ready low for the whole time reset is asserted
    assign req0_ready = rst_n && grant0 && e_accept;
    assign req1_ready = rst_n && grant1 && e_accept;
    assign take       = req0_ready || req1_ready;
    assign sel        = req1_ready;

    assign in_op  = sel ? req1_op  : req0_op;
    assign in_a   = sel ? req1_a   : req0_a;
    assign in_b   = sel ? req1_b   : req0_b;
    assign in_tag = sel ? req1_tag : req0_tag;

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else if (take) begin
            state_nxt = (in_op == ALU_OP_MULT && MUL_MULTI) ? ST_MUL : ST_EXEC;
        end else if (w_load) begin
            state_nxt = ST_IDLE;
        end else if (e_done) begin
            state_nxt = ST_BLOCK;
        end
    end

    // E stage: control and the operand register that drives the ALU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (flush || take) begin
                cnt <= '0;
            end else if (e_valid && !e_done) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_op  <= '0;
            e_a   <= '0;
            e_b   <= '0;
            e_tag <= '0;
            e_src <= 1'b0;
        end else if (take) begin
            e_op  <= in_op;
            e_a   <= in_a;
            e_b   <= in_b;
            e_tag <= in_tag;
            e_src <= sel;
        end
    end

    assign alu_op = e_op;
    assign alu_a  = e_a;
    assign alu_b  = e_b;

    // W stage: result register toward writeback, held under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_src    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_load) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_tag    <= e_tag;
            out_src    <= e_src;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed bench for alu_issue_scheduler with an in-order result scoreboard.
module tb_alu_issue_scheduler;

    localparam int XLEN    = 32;
    localparam int TAG_W   = 6;
    localparam int MUL_LAT = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             req0_valid = 1'b0;
    logic             req0_ready;
    logic [3:0]       req0_op = '0;
    logic [XLEN-1:0]  req0_a = '0;
    logic [XLEN-1:0]  req0_b = '0;
    logic [TAG_W-1:0] req0_tag = '0;
    logic             req1_valid = 1'b0;
    logic             req1_ready;
    logic [3:0]       req1_op = '0;
    logic [XLEN-1:0]  req1_a = '0;
    logic [XLEN-1:0]  req1_b = '0;
    logic [TAG_W-1:0] req1_tag = '0;
    logic [3:0]       alu_op;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [XLEN-1:0]  alu_result;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_src;

    alu_issue_scheduler #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_tag   (req1_tag),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_src    (out_src)
    );

    always #5 clk = ~clk;

    // Environment ALU: 0 ADD, 1 SUB, 2 MULT, anything else XOR
    always_comb begin
        case (alu_op)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a * alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    typedef struct packed {
        logic [3:0]       op;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  exp;
    } vec_t;

    typedef struct packed {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
        logic             src;
    } exp_t;

    vec_t q0[$];
    vec_t q1[$];
    exp_t sb[$];
    int   acc_log[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int used2;
    int used4;
    int used6;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [TAG_W-1:0] tag, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.tag = tag; v.exp = exp;
        return v;
    endfunction

    task automatic drive0(input vec_t v);
        req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b; req0_tag = v.tag;
    endtask

    task automatic drive1(input vec_t v);
        req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b; req1_tag = v.tag;
    endtask

    // Present both port queues; each handshake pushes its expected result
    task automatic run_streams(input int max_cycles, output int used);
        used = 0;
        while ((q0.size() > 0 || q1.size() > 0) && used < max_cycles) begin
            @(posedge clk); #1;
            if (q0.size() > 0) drive0(q0[0]); else req0_valid = 1'b0;
            if (q1.size() > 0) drive1(q1[0]); else req1_valid = 1'b0;
            @(negedge clk);
            used++;
            if (req0_valid && req0_ready) begin
                sb.push_back('{res: q0[0].exp, tag: q0[0].tag, src: 1'b0});
                acc_log.push_back(0);
                void'(q0.pop_front());
            end
            if (req1_valid && req1_ready) begin
                sb.push_back('{res: q1[0].exp, tag: q1[0].tag, src: 1'b1});
                acc_log.push_back(1);
                void'(q1.pop_front());
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("streams_done", 32'(q0.size() + q1.size()), 32'd0);
        q0.delete();
        q1.delete();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() > 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: every consumed result must match the oldest expectation
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got tag %0d result 0x%0h, required no output",
                             out_tag, out_result);
                end else begin
                    mon_e = sb.pop_front();
                    check("result", out_result, mon_e.res);
                    check("result_tag", 32'(out_tag), 32'(mon_e.tag));
                    check("result_src", 32'(out_src), 32'(mon_e.src));
                end
            end
            if (flush) sb.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state with a requester present
        req1_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_ready1", 32'(req1_ready), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_alu_op", 32'(alu_op), 32'd0);
            check("rst_out_result", out_result, 32'd0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        req1_valid = 1'b0;

        // 1: single ADD, result two cycles after accept
        @(posedge clk); #1;
        drive0(mk(4'd0, 32'd5, 32'd7, 6'd3, 32'd12));
        @(negedge clk);
        check("t1_ready0", 32'(req0_ready), 32'd1);
        sb.push_back('{res: 32'd12, tag: 6'd3, src: 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        check("t1_early_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_result", out_result, 32'd12);
        wait_drain();

        // 2: both ports every cycle; port 0 was granted last, so port 1 leads
        acc_log.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(4'd0, 32'(i), 32'd100, 6'(10 + i), 32'(100 + i)));
            q1.push_back(mk(4'd1, 32'd50, 32'(i), 6'(20 + i), 32'(50 - i)));
        end
        run_streams(40, used2);
        check("t2_cycles", 32'(used2), 32'd8);
        check("t2_accepts", 32'(acc_log.size()), 32'd8);
        for (int i = 0; i < acc_log.size(); i++)
            check("t2_grant", 32'(acc_log[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
        wait_drain();

        // 3: MULT on port 1, ports stall two cycles, result at accept+4
        @(posedge clk); #1;
        drive1(mk(4'd2, 32'd6, 32'd7, 6'd9, 32'd42));
        @(negedge clk);
        check("t3_ready1", 32'(req1_ready), 32'd1);
        sb.push_back('{res: 32'd42, tag: 6'd9, src: 1'b1});
        @(posedge clk); #1;
        req1_valid = 1'b0;
        drive0(mk(4'd0, 32'd1, 32'd1, 6'd12, 32'd2));
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            check("t3_stall_ready0", 32'(req0_ready), 32'd0);
            check("t3_stall_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check("t3_ready0_back", 32'(req0_ready), 32'd1);
        check("t3_valid_c3", 32'(out_valid), 32'd0);
        sb.push_back('{res: 32'd2, tag: 6'd12, src: 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        check("t3_valid_c4", 32'(out_valid), 32'd1);
        check("t3_tag_c4", 32'(out_tag), 32'd9);
        wait_drain();

        // 4: backpressure with three ops streaming
        q0.push_back(mk(4'd0, 32'd1, 32'd2, 6'd31, 32'd3));
        q0.push_back(mk(4'd1, 32'd10, 32'd4, 6'd32, 32'd6));
        q0.push_back(mk(4'd4, 32'hF0, 32'h0F, 6'd33, 32'hFF));
        out_ready = 1'b0;
        fork
            run_streams(60, used4);
            begin
                repeat (2) @(negedge clk);
                repeat (4) begin
                    @(negedge clk);
                    check("t4_hold_valid", 32'(out_valid), 32'd1);
                    check("t4_hold_result", out_result, 32'd3);
                    check("t4_hold_tag", 32'(out_tag), 32'd31);
                    check("t4_hold_alu_a", alu_a, 32'd10);
                    check("t4_hold_alu_b", alu_b, 32'd4);
                    check("t4_hold_ready0", 32'(req0_ready), 32'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // 5: flush during the second MULT cycle kills tag 5
        @(posedge clk); #1;
        drive0(mk(4'd2, 32'd3, 32'd3, 6'd5, 32'd9));
        @(negedge clk);
        check("t5_ready0", 32'(req0_ready), 32'd1);
        sb.push_back('{res: 32'd9, tag: 6'd5, src: 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        flush = 1'b1;
        drive1(mk(4'd0, 32'd20, 32'd22, 6'd6, 32'd42));
        @(negedge clk);
        check("t5_flush_ready1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("t5_valid_after_flush", 32'(out_valid), 32'd0);
        check("t5_ready1_after", 32'(req1_ready), 32'd1);
        sb.push_back('{res: 32'd42, tag: 6'd6, src: 1'b1});
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_drain();

        // 6: async reset mid-MULT, then a tie goes to port 0
        @(posedge clk); #1;
        drive0(mk(4'd2, 32'd2, 32'd9, 6'd7, 32'd18));
        @(negedge clk);
        check("t6_ready0", 32'(req0_ready), 32'd1);
        sb.push_back('{res: 32'd18, tag: 6'd7, src: 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        drive1(mk(4'd0, 32'd0, 32'd0, 6'd0, 32'd0));
        #1;
        check("t6_rst_alu_op", 32'(alu_op), 32'd0);
        check("t6_rst_alu_a", alu_a, 32'd0);
        check("t6_rst_alu_b", alu_b, 32'd0);
        check("t6_rst_out_result", out_result, 32'd0);
        check("t6_rst_out_tag", 32'(out_tag), 32'd0);
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        req1_valid = 1'b0;
        acc_log.delete();
        q0.push_back(mk(4'd0, 32'd1, 32'd1, 6'd40, 32'd2));
        q1.push_back(mk(4'd0, 32'd3, 32'd3, 6'd41, 32'd6));
        run_streams(20, used6);
        check("t6_accepts", 32'(acc_log.size()), 32'd2);
        if (acc_log.size() == 2) begin
            check("t6_first_grant", 32'(acc_log[0]), 32'd0);
            check("t6_second_grant", 32'(acc_log[1]), 32'd1);
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
